dsp_pack_seq_ctrl: RTL and testbench

Sequencer for one packed-weight DSP48E2 multiply unit in the conv datapath. Two weights are packed into the pre-adder (low weight on A, high weight on D).
- Pulls feature/weight triples from upstream, issues them with an aligned OPMODE so the unit accumulates one pixel over TAP_NUM taps.
- Captures the final P, unpacks it into two signed results and buffers them in a result FIFO.
- Uses credit-based issue, so the downstream backpressure path never overruns the free-running DSP.

---
 rtl/dsp_pack_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dsp_pack_seq_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pack_seq_ctrl.sv
// Issue/capture sequencer for one packed-weight DSP48E2 multiply unit (two weights per pre-adder).
// Optional bubble counter is built only when DSP_PACK_SEQ_STALL_CNT_EN is defined.
`timescale 1ns/1ps
module dsp_pack_seq_ctrl #(
  parameter int DSP_LAT   = 4,
  parameter int OPM_DLY   = 3,
  parameter int LO_W      = 18,
  parameter int RES_DEPTH = 8
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [7:0]       I_tap_num,
  input  logic [15:0]      I_pix_num,
  output logic             O_busy,
  output logic             O_done,
  input  logic             I_src_valid,
  output logic             O_src_ready,
  input  logic [17:0]      I_feature,
  input  logic [29:0]      I_weight_l,
  input  logic [26:0]      I_weight_h,
  output logic [17:0]      O_dsp_feature,
  output logic [29:0]      O_dsp_weight_l,
  output logic [26:0]      O_dsp_weight_h,
  output logic [8:0]       O_dsp_opmode,
  input  logic [47:0]      I_dsp_p,
  output logic             O_res_valid,
  input  logic             I_res_ready,
  output logic [LO_W-1:0]  O_res_lo,
  output logic [47-LO_W:0] O_res_hi,
  output logic [31:0]      O_stall_cnt,
  output logic [1:0]       O_dbg_state
);
  localparam int HI_W = 48 - LO_W;
  localparam int CW   = $clog2(RES_DEPTH + 1);
  localparam int AW   = $clog2(RES_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RES_DEPTH);
  localparam logic [8:0] OPM_LOAD = 9'b00_000_0101;
  localparam logic [8:0] OPM_ACC  = 9'b00_010_0101;
  localparam logic [8:0] OPM_HOLD = 9'b00_010_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q;
  logic [7:0]      tap_num_q, tap_cnt_q;
  logic [15:0]     pix_num_q, pix_cnt_q;
  logic [CW-1:0]   inflight_q, fifo_cnt_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LO_W-1:0] mem_lo_q [RES_DEPTH];
  logic [HI_W-1:0] mem_hi_q [RES_DEPTH];
  logic [17:0]     feature_q;
  logic [29:0]     weight_l_q;
  logic [26:0]     weight_h_q;
  logic [8:0]      slot_opm_q;
  logic [8:0]      opm_dly_q [OPM_DLY];
  logic            last_q;
  logic [DSP_LAT-1:0] lat_sr_q;

  logic tap0, last_tap, credit_ok, src_ready, issue, push, pop;
  logic [LO_W-1:0] cap_lo;
  logic [HI_W-1:0] cap_hi;

  // Credits are only charged at tap 0: a pixel that has started always finishes.
  assign tap0      = (tap_cnt_q == 8'd0);
  assign last_tap  = (tap_cnt_q == tap_num_q - 8'd1);
  assign credit_ok = !tap0 || (({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < DEPTH_C);
  assign src_ready = (state_q == S_RUN) && credit_ok;
  assign issue     = I_src_valid && src_ready;
  assign push      = lat_sr_q[DSP_LAT-1];
  assign pop       = (fifo_cnt_q != '0) && I_res_ready;

  // The low field is signed, so a negative low result borrows one from the high field.
  assign cap_lo = I_dsp_p[LO_W-1:0];
  assign cap_hi = I_dsp_p[47:LO_W] + {{(HI_W-1){1'b0}}, I_dsp_p[LO_W-1]};

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= S_IDLE;
      tap_num_q  <= '0;
      pix_num_q  <= '0;
      tap_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      inflight_q <= '0;
    end else begin
      if (issue && tap0 && !push)
        inflight_q <= inflight_q + CW'(1);
      else if (push && !(issue && tap0))
        inflight_q <= inflight_q - CW'(1);
      case (state_q)
        S_IDLE: begin
          if (I_start) begin
            tap_num_q <= I_tap_num;
            pix_num_q <= I_pix_num;
            tap_cnt_q <= '0;
            pix_cnt_q <= '0;
            state_q   <= (I_tap_num != '0 && I_pix_num != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (last_tap) begin
              tap_cnt_q <= '0;
              pix_cnt_q <= pix_cnt_q + 16'd1;
              if (pix_cnt_q == pix_num_q - 16'd1) state_q <= S_DRAIN;
            end else begin
              tap_cnt_q <= tap_cnt_q + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (push && inflight_q == CW'(1)) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      feature_q  <= '0;
      weight_l_q <= '0;
      weight_h_q <= '0;
      slot_opm_q <= '0;
      last_q     <= 1'b0;
      lat_sr_q   <= '0;
      for (int i = 0; i < OPM_DLY; i++) opm_dly_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      feature_q  <= issue ? I_feature  : '0;
      weight_l_q <= issue ? I_weight_l : '0;
      weight_h_q <= issue ? I_weight_h : '0;
      slot_opm_q <= issue ? (tap0 ? OPM_LOAD : OPM_ACC) : OPM_HOLD;
      last_q     <= issue && last_tap;
      lat_sr_q   <= {lat_sr_q[DSP_LAT-2:0], last_q};
      opm_dly_q[0] <= slot_opm_q;
      for (int i = 1; i < OPM_DLY; i++) opm_dly_q[i] <= opm_dly_q[i-1];
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)
        fifo_cnt_q <= fifo_cnt_q + CW'(1);
      else if (pop && !push)
        fifo_cnt_q <= fifo_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge I_clk) begin
    if (push) begin
      mem_lo_q[wr_ptr_q] <= cap_lo;
      mem_hi_q[wr_ptr_q] <= cap_hi;
    end
  end

`ifdef DSP_PACK_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge I_clk) begin
    if (I_rst)
      stall_q <= '0;
    else if (state_q == S_IDLE && I_start)
      stall_q <= '0;
    else if (state_q == S_RUN && !issue && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end
  assign O_stall_cnt = stall_q;
`else
  assign O_stall_cnt = '0;
`endif

  assign O_busy         = (state_q != S_IDLE);
  assign O_done         = (state_q == S_DONE);
  assign O_src_ready    = src_ready;
  assign O_dsp_feature  = feature_q;
  assign O_dsp_weight_l = weight_l_q;
  assign O_dsp_weight_h = weight_h_q;
  assign O_dsp_opmode   = opm_dly_q[OPM_DLY-1];
  assign O_res_valid    = (fifo_cnt_q != '0);
  assign O_res_lo       = O_res_valid ? mem_lo_q[rd_ptr_q] : '0;
  assign O_res_hi       = O_res_valid ? mem_hi_q[rd_ptr_q] : '0;
  assign O_dbg_state    = state_q;
endmodule

// File: tb/tb_dsp_pack_seq_ctrl.sv
// Directed bench for dsp_pack_seq_ctrl with a behavioural DSP48E2 model driving I_dsp_p.
`timescale 1ns/1ps
module tb_dsp_pack_seq_ctrl;
  localparam int LO_W = 18;
  localparam int HI_W = 30;
  localparam int LOGN = 2048;
`ifdef DSP_PACK_SEQ_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd3;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  // clock / reset
  logic I_clk = 1'b0;
  logic I_rst = 1'b1;
  always #5 I_clk = ~I_clk;

  logic        I_start = 0, I_src_valid = 0, I_res_ready = 1;
  logic [7:0]  I_tap_num = 0;
  logic [15:0] I_pix_num = 0;
  logic [17:0] I_feature = 0;
  logic [29:0] I_weight_l = 0;
  logic [26:0] I_weight_h = 0;
  logic [47:0] I_dsp_p;
  logic        O_busy, O_done, O_src_ready, O_res_valid;
  logic [17:0] O_dsp_feature;
  logic [29:0] O_dsp_weight_l;
  logic [26:0] O_dsp_weight_h;
  logic [8:0]  O_dsp_opmode;
  logic [LO_W-1:0] O_res_lo;
  logic [HI_W-1:0] O_res_hi;
  logic [31:0] O_stall_cnt;
  logic [1:0]  O_dbg_state;

  dsp_pack_seq_ctrl dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_tap_num(I_tap_num),
    .I_pix_num(I_pix_num), .O_busy(O_busy), .O_done(O_done),
    .I_src_valid(I_src_valid), .O_src_ready(O_src_ready), .I_feature(I_feature),
    .I_weight_l(I_weight_l), .I_weight_h(I_weight_h), .O_dsp_feature(O_dsp_feature),
    .O_dsp_weight_l(O_dsp_weight_l), .O_dsp_weight_h(O_dsp_weight_h),
    .O_dsp_opmode(O_dsp_opmode), .I_dsp_p(I_dsp_p), .O_res_valid(O_res_valid),
    .I_res_ready(I_res_ready), .O_res_lo(O_res_lo), .O_res_hi(O_res_hi),
    .O_stall_cnt(O_stall_cnt), .O_dbg_state(O_dbg_state)
  );

  // DSP model: M = (A + D) * B, opmode consumed OPM_DLY cycles after its operands
  logic [47:0] mh0 = 0, mh1 = 0, mh2 = 0, p_model = 0;
  logic [47:0] a_s, d_s, b_s, m_cur;
  always_comb begin
    a_s   = {{18{O_dsp_weight_l[29]}}, O_dsp_weight_l};
    d_s   = {{21{O_dsp_weight_h[26]}}, O_dsp_weight_h};
    b_s   = {{30{O_dsp_feature[17]}}, O_dsp_feature};
    m_cur = (a_s + d_s) * b_s;
  end
  always @(posedge I_clk) begin
    case (O_dsp_opmode)
      9'h005:  p_model <= mh2;
      9'h025:  p_model <= p_model + mh2;
      default: p_model <= p_model;
    endcase
    mh2 <= mh1;
    mh1 <= mh0;
    mh0 <= m_cur;
  end
  assign I_dsp_p = p_model;

  // monitor / scoreboard
  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;
  logic [8:0]  opm_log  [LOGN];
  logic [17:0] feat_log [LOGN];
  logic [29:0] wl_log   [LOGN];
  logic [26:0] wh_log   [LOGN];
  logic        iss_log  [LOGN];
  int issue_q[$];
  int done_cnt = 0, done_cyc = -1, start_cyc = -1;
  logic [47:0] got_q[$];
  logic [47:0] exp_q[$];
  always @(negedge I_clk) begin
    if (cyc < LOGN) begin
      opm_log[cyc]  = O_dsp_opmode;
      feat_log[cyc] = O_dsp_feature;
      wl_log[cyc]   = O_dsp_weight_l;
      wh_log[cyc]   = O_dsp_weight_h;
      iss_log[cyc]  = I_src_valid && O_src_ready;
    end
    if (I_src_valid && O_src_ready) issue_q.push_back(cyc);
    if (O_res_valid && I_res_ready) got_q.push_back({O_res_hi, O_res_lo});
    if (O_done) begin done_cnt++; done_cyc = cyc; end
    if (I_start) start_cyc = cyc;
  end

  int checks = 0, failures = 0;
  logic [17:0] op_f[$];
  logic [29:0] op_l[$];
  logic [26:0] op_h[$];
  int feed_idx;

  // driver tasks
  task automatic start_job(input logic [7:0] tap, input logic [15:0] pix);
    got_q.delete(); exp_q.delete(); issue_q.delete(); feed_idx = 0;
    @(posedge I_clk); #1;
    I_tap_num = tap; I_pix_num = pix; I_start = 1'b1;
    @(posedge I_clk); #1;
    I_start = 1'b0;
  endtask

  task automatic feed_ops(input int n, input bit toggle, input int budget);
    int used = 0;
    bit ph = 1'b1;
    bit acc;
    while (feed_idx < n && used < budget) begin
      I_src_valid = toggle ? ph : 1'b1;
      I_feature = op_f[feed_idx]; I_weight_l = op_l[feed_idx]; I_weight_h = op_h[feed_idx];
      @(negedge I_clk);
      acc = I_src_valid && O_src_ready;
      @(posedge I_clk); #1;
      if (acc) feed_idx++;
      ph = ~ph; used++;
    end
    I_src_valid = 1'b0; I_feature = '0; I_weight_l = '0; I_weight_h = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int c0 = done_cnt;
    int n = 0;
    while (done_cnt == c0 && n < budget) begin @(negedge I_clk); n++; end
    ok = (done_cnt != c0);
    repeat (4) @(negedge I_clk);
  endtask

  task automatic set_ops(input int n, input logic [17:0] f0, input logic [17:0] fstep,
                         input logic [29:0] wl, input logic [26:0] wh);
    op_f.delete(); op_l.delete(); op_h.delete();
    for (int i = 0; i < n; i++) begin
      op_f.push_back(f0 + fstep * 18'(i)); op_l.push_back(wl); op_h.push_back(wh);
    end
  endtask

  // tests
  task automatic test_reset();
    @(posedge I_clk); #1;
    checks++;
    if ({O_busy, O_done, O_src_ready, O_res_valid} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {O_busy, O_done, O_src_ready, O_res_valid});
    end
    checks++;
    if ({O_dsp_feature, O_dsp_weight_l, O_dsp_weight_h} !== 75'd0) begin
      failures++; $display("FAIL reset_operands got=%h exp=0", {O_dsp_feature, O_dsp_weight_l, O_dsp_weight_h});
    end
    checks++;
    if (O_dsp_opmode !== 9'h000) begin
      failures++; $display("FAIL reset_opmode got=%h exp=000", O_dsp_opmode);
    end
    checks++;
    if ({O_res_hi, O_res_lo} !== 48'd0 || O_stall_cnt !== 32'd0 || O_dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_results got=%h/%0d/%0d exp=0/0/0", {O_res_hi, O_res_lo}, O_stall_cnt, O_dbg_state);
    end
    I_rst = 1'b0;
    repeat (6) @(posedge I_clk); #1;
    checks++;
    if (O_dsp_opmode !== 9'h020) begin
      failures++; $display("FAIL idle_opmode got=%h exp=020", O_dsp_opmode);
    end
  endtask

  task automatic test_single_tap();
    bit ok;
    int d0 = done_cnt;
    int k;
    set_ops(1, 18'd3, 18'd0, 30'd5, 27'd2 << 18);
    start_job(8'd1, 16'd1);
    exp_q.push_back({30'd6, 18'd15});
    feed_ops(1, 1'b0, 50);
    wait_done(60, ok);
    checks++;
    if (!ok || done_cnt != d0 + 1) begin
      failures++; $display("FAIL single_done got=%0d exp=%0d", done_cnt - d0, 1);
    end
    checks++;
    if (issue_q.size() != 1) begin
      failures++; $display("FAIL single_issue_count got=%0d exp=1", issue_q.size());
    end else begin
      k = issue_q[0];
      checks++;
      if (feat_log[k+1] !== 18'd3 || wl_log[k+1] !== 30'd5) begin
        failures++; $display("FAIL single_operands got=%0d/%0d exp=3/5", feat_log[k+1], wl_log[k+1]);
      end
      checks++;
      if (opm_log[k+3] !== 9'h020 || opm_log[k+4] !== 9'h005) begin
        failures++; $display("FAIL single_opmode_align got=%h,%h exp=020,005", opm_log[k+3], opm_log[k+4]);
      end
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL single_result got=%0d items first=%h exp=%h", got_q.size(), got_q.size() ? got_q[0] : 48'd0, exp_q[0]);
    end
    checks++;
    if (O_busy !== 1'b0) begin
      failures++; $display("FAIL single_busy_after got=%b exp=0", O_busy);
    end
  endtask

  task automatic test_accumulate();
    bit ok;
    logic [8:0] exp_opm;
    set_ops(4, 18'd1, 18'd1, 30'd5, 27'd2 << 18);
    start_job(8'd4, 16'd1);
    exp_q.push_back({30'd20, 18'd50});
    feed_ops(4, 1'b0, 50);
    wait_done(60, ok);
    checks++;
    if (!ok || issue_q.size() != 4) begin
      failures++; $display("FAIL accum_issue got=%0d done=%0b exp=4 done=1", issue_q.size(), ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_opm = (i == 0) ? 9'h005 : 9'h025;
        checks++;
        if (opm_log[issue_q[i]+4] !== exp_opm) begin
          failures++; $display("FAIL accum_opmode tap=%0d got=%h exp=%h", i, opm_log[issue_q[i]+4], exp_opm);
        end
      end
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL accum_result got=%0d items first=%h exp=%h", got_q.size(), got_q.size() ? got_q[0] : 48'd0, exp_q[0]);
    end
  endtask

  task automatic test_borrow();
    bit ok;
    set_ops(1, 18'd2, 18'd0, 30'h3FFFFFFF, 27'd1 << 18);
    start_job(8'd1, 16'd1);
    exp_q.push_back({30'd2, 18'h3FFFE});
    feed_ops(1, 1'b0, 50);
    wait_done(60, ok);
    checks++;
    if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL borrow_result got=%0d items first=%h exp=%h", got_q.size(), got_q.size() ? got_q[0] : 48'd0, exp_q[0]);
    end
  endtask

  task automatic test_bubbles();
    bit ok;
    int nb = 0;
    set_ops(4, 18'd1, 18'd1, 30'd5, 27'd2 << 18);
    start_job(8'd4, 16'd1);
    exp_q.push_back({30'd20, 18'd50});
    feed_ops(4, 1'b1, 50);
    wait_done(60, ok);
    checks++;
    if (!ok || issue_q.size() != 4) begin
      failures++; $display("FAIL bubble_issue got=%0d exp=4", issue_q.size());
    end else begin
      for (int k = issue_q[0]; k < issue_q[3]; k++) begin
        if (!iss_log[k]) begin
          nb++;
          checks++;
          if ({feat_log[k+1], wl_log[k+1], wh_log[k+1]} !== 75'd0 || opm_log[k+4] !== 9'h020) begin
            failures++; $display("FAIL bubble_slot cyc=%0d got=%0d/%h exp=0/020", k, feat_log[k+1], opm_log[k+4]);
          end
        end
      end
      checks++;
      if (nb != 3) begin
        failures++; $display("FAIL bubble_count got=%0d exp=3", nb);
      end
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL bubble_result got=%0d items first=%h exp=%h", got_q.size(), got_q.size() ? got_q[0] : 48'd0, exp_q[0]);
    end
    checks++;
    if (O_stall_cnt !== EXP_STALL) begin
      failures++; $display("FAIL bubble_stall_cnt got=%0d exp=%0d", O_stall_cnt, EXP_STALL);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int d0 = done_cnt;
    set_ops(20, 18'd1, 18'd1, 30'd1, 27'd1 << 18);
    I_res_ready = 1'b0;
    start_job(8'd1, 16'd20);
    for (int i = 0; i < 20; i++) exp_q.push_back({30'(i + 1), 18'(i + 1)});
    feed_ops(20, 1'b0, 40);
    @(negedge I_clk);
    checks++;
    if (feed_idx != 8) begin
      failures++; $display("FAIL bp_accepted got=%0d exp=8", feed_idx);
    end
    checks++;
    if (O_src_ready !== 1'b0 || O_res_valid !== 1'b1 || O_res_lo !== 18'd1) begin
      failures++; $display("FAIL bp_stalled got=rdy%b vld%b lo%0d exp=rdy0 vld1 lo1", O_src_ready, O_res_valid, O_res_lo);
    end
    @(posedge I_clk); #1;
    I_res_ready = 1'b1;
    feed_ops(20, 1'b0, 200);
    wait_done(100, ok);
    checks++;
    if (!ok || done_cnt != d0 + 1) begin
      failures++; $display("FAIL bp_done got=%0d exp=1", done_cnt - d0);
    end
    checks++;
    if (got_q.size() != 20) begin
      failures++; $display("FAIL bp_count got=%0d exp=20", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int d0 = done_cnt;
    int stray = 0;
    set_ops(4, 18'd7, 18'd1, 30'd3, 27'd1 << 18);
    start_job(8'd1, 16'd4);
    feed_ops(3, 1'b0, 10);
    I_rst = 1'b1;
    @(posedge I_clk); #1;
    checks++;
    if ({O_busy, O_done, O_src_ready, O_res_valid, O_dbg_state} !== 6'd0) begin
      failures++; $display("FAIL midrst_flags got=%b exp=000000", {O_busy, O_done, O_src_ready, O_res_valid, O_dbg_state});
    end
    checks++;
    if ({O_dsp_feature, O_dsp_weight_l, O_dsp_weight_h, O_dsp_opmode} !== 84'd0) begin
      failures++; $display("FAIL midrst_dsp got=%h exp=0", {O_dsp_feature, O_dsp_weight_l, O_dsp_weight_h, O_dsp_opmode});
    end
    I_rst = 1'b0;
    repeat (12) begin
      @(negedge I_clk);
      if (O_res_valid || O_done) stray++;
    end
    checks++;
    if (stray != 0 || got_q.size() != 0 || done_cnt != d0) begin
      failures++; $display("FAIL midrst_stale got=%0d cycles %0d results exp=0 0", stray, got_q.size());
    end
  endtask

  task automatic test_zero_pix();
    int d0 = done_cnt;
    start_job(8'd4, 16'd0);
    repeat (4) @(negedge I_clk);
    checks++;
    if (done_cnt != d0 + 1 || done_cyc != start_cyc + 1) begin
      failures++; $display("FAIL zero_pix_done got=%0d pulses at +%0d exp=1 at +1", done_cnt - d0, done_cyc - start_cyc);
    end
    checks++;
    if (issue_q.size() != 0) begin
      failures++; $display("FAIL zero_pix_issue got=%0d exp=0", issue_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge I_clk);
    test_reset();
    test_single_tap();
    test_accumulate();
    test_borrow();
    test_bubbles();
    test_backpressure();
    test_mid_reset();
    test_zero_pix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
